// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, mid-bit majority sampling,
// LSB-first deserialisation, optional parity check and stop-bit check.
// Bit timing comes from an external edge/bit counter that this block enables.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            prescale,
  input  logic [5:0]            edge_cnt,
  input  logic [3:0]            bit_cnt,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [DATA_WIDTH-1:0] pdata_nxt;
  logic                  err_q, err_nxt;
  logic                  dv_nxt, pe_nxt, se_nxt;
  logic                  samp0_q, samp1_q, bit_val_q;

  logic [5:0] mid, mid_m1, mid_p1;
  logic       bit_end;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign mid     = prescale >> 1;
  assign mid_m1  = mid - 6'd1;
  assign mid_p1  = mid + 6'd1;
  assign bit_end = (edge_cnt == (prescale - 6'd1));

  // Three samples around mid-bit; the vote lands one cycle after the centre.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp0_q   <= 1'b0;
      samp1_q   <= 1'b0;
      bit_val_q <= 1'b0;
    end else begin
      if (edge_cnt == mid_m1) samp0_q <= RX_IN;
      if (edge_cnt == mid)    samp1_q <= RX_IN;
      if (edge_cnt == mid_p1) bit_val_q <= maj3(samp0_q, samp1_q, RX_IN);
    end
  end

  // Frame sequencing; every decision is taken on the last edge of a bit.
  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    err_nxt   = err_q;
    pdata_nxt = P_DATA;
    dv_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    se_nxt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!RX_IN) state_nxt = START;
      end
      START: begin
        if (bit_end) state_nxt = bit_val_q ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = {bit_val_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt == 4'(DATA_WIDTH)) state_nxt = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (bit_val_q != ((^shift_q) ^ PAR_TYP)) begin
            pe_nxt  = 1'b1;
            err_nxt = 1'b1;
          end
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!bit_val_q) begin
            se_nxt = 1'b1;
          end else if (!err_q) begin
            pdata_nxt = shift_q;
            dv_nxt    = 1'b1;
          end
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs; the counter enable follows the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      err_q      <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      cnt_enable <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      shift_q    <= shift_nxt;
      err_q      <= err_nxt;
      P_DATA     <= pdata_nxt;
      data_valid <= dv_nxt;
      par_err    <= pe_nxt;
      stp_err    <= se_nxt;
      cnt_enable <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter stage.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       cnt_enable;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int e0_cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
  logic [7:0] dv_data = 8'h00;

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .cnt_enable (cnt_enable),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Counter stage model: cleared while disabled, wraps edge_cnt at prescale-1.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (!cnt_enable) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (edge_cnt == prescale - 6'd1) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // Pulse monitor: counts high cycles of each strobe and notes when they occur.
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_cyc  <= cyc;
      dv_data <= P_DATA;
    end
    if (par_err) begin
      pe_cnt <= pe_cnt + 1;
      pe_cyc <= cyc;
    end
    if (stp_err) begin
      se_cnt <= se_cnt + 1;
      se_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a frame bit by bit, each bit held for prescale clock edges.
  // glitch_k selects a bit to invert for one cycle (edge_cnt 4 within it).
  task automatic send_frame(input logic [7:0] d, input bit par_on, input bit par_bit,
                            input bit stop_bit, input int glitch_k, input int nbits);
    logic [10:0] bits;
    int n;
    int p;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (par_on) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      n = 11;
    end else begin
      bits[9]  = stop_bit;
      bits[10] = 1'b1;
      n = 10;
    end
    if (nbits < n) n = nbits;
    p = int'(prescale);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge CLK);
        if (k == 0 && j == 0) e0_cyc = cyc + 1;
        RX_IN = (k == glitch_k && j == 5) ? ~bits[k] : bits[k];
      end
    end
  endtask

  task automatic line_idle(input int n);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  int dv0, pe0, se0, first_e0;

  initial begin
    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_pdata", P_DATA, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_pe", par_err, 1'b0);
    check("rst_se", stp_err, 1'b0);
    check("rst_cnten", cnt_enable, 1'b0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // prescale 8, no parity, 0xA5
    prescale = 6'd8; PAR_EN = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 11);
    line_idle(6);
    check("a5_dv_cnt", dv_cnt - dv0, 1);
    check("a5_data", dv_data, 8'hA5);
    check("a5_lat", dv_cyc - e0_cyc, 80);
    check("a5_pe", pe_cnt - pe0, 0);
    check("a5_se", se_cnt - se0, 0);
    check("a5_pdata", P_DATA, 8'hA5);

    // prescale 16, even parity, 0x3C with correct parity bit
    prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, 11);
    line_idle(6);
    check("3c_dv_cnt", dv_cnt - dv0, 1);
    check("3c_lat", dv_cyc - e0_cyc, 176);
    check("3c_pdata", P_DATA, 8'h3C);
    check("3c_pe", pe_cnt - pe0, 0);

    // same byte, wrong parity bit
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, 11);
    line_idle(6);
    check("perr_cnt", pe_cnt - pe0, 1);
    check("perr_lat", pe_cyc - e0_cyc, 160);
    check("perr_dv", dv_cnt - dv0, 0);
    check("perr_se", se_cnt - se0, 0);
    check("perr_pdata", P_DATA, 8'h3C);

    // false start at prescale 8: line low for two edges only
    prescale = 6'd8; PAR_EN = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK);
    @(negedge CLK); RX_IN = 1'b1;
    repeat (6) @(negedge CLK);
    check("fs_cnten_e7", cnt_enable, 1'b1);
    @(negedge CLK);
    check("fs_cnten_e8", cnt_enable, 1'b0);
    repeat (20) @(negedge CLK);
    check("fs_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("fs_pdata", P_DATA, 8'h3C);

    // prescale 32, 0xFF with stop bit 0
    prescale = 6'd32; PAR_EN = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, -1, 11);
    line_idle(6);
    check("serr_cnt", se_cnt - se0, 1);
    check("serr_lat", se_cyc - e0_cyc, 320);
    check("serr_dv", dv_cnt - dv0, 0);
    check("serr_pe", pe_cnt - pe0, 0);
    check("serr_pdata", P_DATA, 8'h3C);

    // prescale 8, one-cycle glitch in the middle of data bit 3 of 0x5A
    prescale = 6'd8;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 4, 11);
    line_idle(6);
    check("gl_dv_cnt", dv_cnt - dv0, 1);
    check("gl_data", dv_data, 8'h5A);
    check("gl_lat", dv_cyc - e0_cyc, 80);
    check("gl_errs", (pe_cnt - pe0) + (se_cnt - se0), 0);

    // back-to-back 0x55 then 0xAA, reset partway through the second frame
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 11);
    first_e0 = e0_cyc;
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, -1, 5);
    check("b2b_dv_cnt", dv_cnt - dv0, 1);
    check("b2b_data", dv_data, 8'h55);
    check("b2b_lat", dv_cyc - first_e0, 80);
    check("b2b_midframe_en", cnt_enable, 1'b1);
    @(negedge CLK);
    RST = 1'b1; RX_IN = 1'b1;
    @(negedge CLK);
    check("b2b_rst_pdata", P_DATA, 8'h00);
    check("b2b_rst_cnten", cnt_enable, 1'b0);
    check("b2b_rst_dv", data_valid, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (200) @(negedge CLK);
    check("post_rst_dv", dv_cnt - dv0, 1);
    check("post_rst_errs", (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("post_rst_cnten", cnt_enable, 1'b0);
    check("post_rst_pdata", P_DATA, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Receive-side controller for the UART RX path.
- Detects the start bit and drives the enable of the edge/bit counter stage.
- Consumes that stage's edge_cnt and bit_cnt to majority-sample RX_IN mid-bit, deserialize 8 data bits LSB-first, and check optional parity and the stop bit.
- Delivers the received byte with a single-cycle valid strobe, plus error pulses, to the downstream register/sync logic.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; only 8 is supported.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line, already synchronized upstream; idle high.
- PAR_EN  input  1  1 = frame carries a parity bit; must be stable while a frame is in progress.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- prescale  input  6  oversampling ratio; legal values are 8, 16 and 32; other values give undefined behaviour.
- edge_cnt  input  6  from the counter stage; 0..prescale-1 within the current bit.
- bit_cnt  input  4  from the counter stage; index of the current bit, with start bit = 0.
- cnt_enable  output  1  enable to the counter stage; counters clear when it is low.
- P_DATA  output  8  last correctly received byte.
- data_valid  output  1  one-cycle strobe when P_DATA updates.
- par_err  output  1  one-cycle pulse on parity mismatch.
- stp_err  output  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (RST=1, any time including mid-frame):
  - state=IDLE and cnt_enable=0.
  - P_DATA=0x00; data_valid, par_err and stp_err=0.
  - Shift register, sample registers and internal error flag are cleared.
- All outputs are registered.
- Let mid = prescale>>1. Let bit_end = (edge_cnt == prescale-1).
- Sampling:
  - RX_IN is captured when edge_cnt==mid-1 and when edge_cnt==mid.
  - When edge_cnt==mid+1, bit_val <= majority(sample0, sample1, RX_IN).
  - bit_val holds until the next mid+1.
- States: IDLE, START, DATA, PARITY, STOP.
- cnt_enable = 1 in every state except IDLE.
- IDLE:
  - When RX_IN==0 is seen at a clock edge (E0), go to START. The counter then starts at edge_cnt=0 on the cycle after E0.
  - Bit k therefore ends at edge E((k+1)*prescale).
- START, on bit_end:
  - bit_val==1 means a false start (glitch): go to IDLE with no outputs.
  - Otherwise go to DATA.
- DATA, on bit_end:
  - Shift right with bit_val into bit 7, so LSB is received first.
  - If bit_cnt==8, go to PARITY when PAR_EN=1, else go to STOP.
  - Otherwise stay in DATA.
- PARITY, on bit_end:
  - expected = XOR(shift register) XOR PAR_TYP.
  - If bit_val != expected: par_err=1 for one cycle and set the internal error flag.
  - Go to STOP.
- STOP, on bit_end:
  - If bit_val==0: stp_err=1 for one cycle.
  - Else if the error flag is clear: P_DATA <= shift register and data_valid=1 for one cycle.
  - Clear the error flag and go to IDLE.
- Latency, measured from E0 to the data_valid cycle:
  - 10*prescale cycles without parity.
  - 11*prescale cycles with parity.
- Back-to-back frames: IDLE may detect a new start on the first cycle after returning. cnt_enable drops for at least one cycle, so the counters reset between frames.
- The first frame after reset is rejected (errored) unless RX_IN stays high until a genuine start edge.
- P_DATA holds its value across errored frames and false starts.
- Only one of data_valid, par_err and stp_err asserts per frame, with this exception: par_err and stp_err may both fire, on different cycles.
- Changing prescale mid-frame is illegal and undefined.

Test Plan:
- prescale=8, PAR_EN=0, send 0xA5 with a valid stop bit -> data_valid high for 1 cycle exactly 80 cycles after E0, P_DATA=0xA5, par_err=stp_err=0.
- prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid at 176 cycles, P_DATA=0x3C. Repeat with a wrong parity bit 1 -> par_err pulse at 160 cycles, no data_valid, P_DATA remains 0x3C.
- prescale=8, RX_IN low for 2 cycles then high -> return to IDLE after 8 cycles, cnt_enable falls, no output pulses.
- prescale=32, PAR_EN=0, send 0xFF with stop bit 0 -> stp_err pulse at 320 cycles, no data_valid, P_DATA unchanged.
- prescale=8, single-cycle glitch on RX_IN at edge_cnt=4 of data bit 3 -> majority vote rejects it, byte received correctly.
- Two frames 0x55 then 0xAA, with the next start bit immediately after the stop bit, plus RST asserted mid-way through the second frame -> first data_valid with 0x55; after reset, P_DATA=0x00, cnt_enable=0, state IDLE, no further pulses.
